// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

  // A single-nibble build still needs a one-bit counter to stay a legal vector.
  function automatic int cnt_width(input int width);
    int n;
    n = nibbles(width);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// Combinational 4-bit carry-lookahead slice; the carry into bit 3 is exposed for overflow.
module cla_4bit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Every carry is flattened from generate/propagate terms rather than rippled.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
  assign o_c3   = w_c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract that pushes one nibble per clock through a single CLA slice.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            NIB  = nibbles(WIDTH);
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  generate
    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_c3;
  logic [WIDTH-1:0] w_sum_next;

  cla_4bit_adder u_cla (
    .i_a    (r_a[NIBBLE_W-1:0]),
    .i_b    (r_b[NIBBLE_W-1:0]),
    .i_cin  (r_c),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_c3   (w_slice_c3)
  );

  // Operands shift down so the slice always sees bit 0; results enter at the top, LSB nibble first.
  generate
    if (WIDTH == NIBBLE_W) begin : g_single
      assign w_sum_next = w_slice_sum;
    end else begin : g_multi
      assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub | cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> NIBBLE_W;
          r_b   <= r_b >> NIBBLE_W;
          r_sum <= w_sum_next;
          r_c   <= w_slice_cout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout  <= w_slice_cout;
            r_ovf   <= w_slice_c3 ^ w_slice_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: 16-bit instance with monitor, plus a 4-bit build.
module tb_nibble_serial_adder;

  localparam int W  = 16;
  localparam int W4 = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, sum;

  logic          u4_in_valid, u4_in_ready, u4_cin, u4_sub, u4_out_valid, u4_out_ready, u4_cout, u4_ovf;
  logic [W4-1:0] u4_a, u4_b, u4_sum;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .a(u4_a), .b(u4_b), .cin(u4_cin), .sub(u4_sub),
    .out_valid(u4_out_valid), .out_ready(u4_out_ready),
    .sum(u4_sum), .cout(u4_cout), .ovf(u4_ovf)
  );

  exp_t expQ[$];
  exp_t monE;
  int   checks       = 0;
  int   errors       = 0;
  int   cyc          = 0;
  int   acceptCyc    = 0;
  int   handshakeCyc = 0;
  logic prevValid    = 1'b0;
  bit   randReady    = 1'b0;

  // Reference: plain integer arithmetic, signed overflow from the representable range.
  function automatic exp_t model(input int w, input longint av, input longint bv, input bit ci, input bit sb);
    exp_t   r;
    longint modv, half, total, sa, sbv, sres;
    modv  = longint'(1) << w;
    half  = longint'(1) << (w - 1);
    total = sb ? (av + modv - bv) : (av + bv + longint'(ci));
    sa    = (av >= half) ? av - modv : av;
    sbv   = (bv >= half) ? bv - modv : bv;
    sres  = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    r.sum  = 16'(total % modv);
    r.cout = (total >= modv);
    r.ovf  = (sres > half - 1) || (sres < -half);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      expQ.push_back(model(W, longint'(av), longint'(bv), ci, sb));
      acceptCyc = cyc + 1;
    end else begin
      checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic ci, input logic sb);
    exp_t e;
    @(posedge clk); #1;
    u4_a = av; u4_b = bv; u4_cin = ci; u4_sub = sb; u4_in_valid = 1'b1;
    @(negedge clk);
    checkOutput("w4_in_ready", {31'd0, u4_in_ready}, 32'd1);
    e = model(W4, longint'(av), longint'(bv), ci, sb);
    @(posedge clk); #1;
    u4_in_valid = 1'b0;
    u4_a = 4'($urandom); u4_b = 4'($urandom); u4_cin = 1'($urandom); u4_sub = 1'($urandom);
    @(negedge clk);
    checkOutput("w4_valid_early", {31'd0, u4_out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("w4_valid_1clk", {31'd0, u4_out_valid}, 32'd1);
    checkOutput("w4_sum", {28'd0, u4_sum}, {16'd0, e.sum});
    checkOutput("w4_cout", {31'd0, u4_cout}, {31'd0, e.cout});
    checkOutput("w4_ovf", {31'd0, u4_ovf}, {31'd0, e.ovf});
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (randReady) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on each rising out_valid, scoreboard pop on each output handshake.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prevValid !== 1'b1) begin
      checkOutput("latency", cyc - acceptCyc, 32'd4);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("sum", {16'd0, sum}, {16'd0, monE.sum});
        checkOutput("cout", {31'd0, cout}, {31'd0, monE.cout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, monE.ovf});
      end
      handshakeCyc = cyc + 1;
    end
    prevValid = out_valid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e1, e2;
    bit   got, sawValid;
    logic [15:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    u4_in_valid = 1'b0; u4_a = '0; u4_b = '0; u4_cin = 1'b0; u4_sub = 1'b0; u4_out_ready = 1'b1;

    #12;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_sum", {16'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset_w4_out_valid", {31'd0, u4_out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    checkOutput("out_valid_after_reset", {31'd0, out_valid}, 32'd0);

    $display("[TB] directed operations");
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] random operations with random out_ready");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) rb = ~ra;
      applyStimulus(ra, rb, 1'($urandom), 1'($urandom));
    end
    randReady = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] backpressure and held request");
    @(posedge clk); #1;
    out_ready = 1'b0;
    e1 = model(W, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
    e2 = model(W, 64'h00FF, 64'h0F01, 1'b1, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b1; a = 16'h00FF; b = 16'h0F01; cin = 1'b1; sub = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("bp_reach_done", {31'd0, got}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_sum", {16'd0, sum}, {16'd0, e1.sum});
      checkOutput("bp_cout", {31'd0, cout}, {31'd0, e1.cout});
      checkOutput("bp_ovf", {31'd0, ovf}, {31'd0, e1.ovf});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      expQ.push_back(e2);
      acceptCyc = cyc + 1;
      checkOutput("accept_after_handshake", cyc + 1, handshakeCyc + 1);
    end else begin
      checkOutput("second_accept_timeout", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] reset during RUN");
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    expQ.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_sum", {16'd0, sum}, 32'd0);
    checkOutput("midreset_cout", {31'd0, cout}, 32'd0);
    checkOutput("midreset_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("no_valid_after_reset", {31'd0, sawValid}, 32'd0);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] WIDTH=4 build");
    run4(4'h9, 4'h8, 1'b1, 1'b0);
    run4(4'h7, 4'h1, 1'b0, 1'b0);
    run4(4'h3, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
